// File: rtl/button_debouncer_pkg.sv
// Shared types and default constants for the push-button debouncer.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        S_RELEASED       = 2'd0,
        S_MAYBE_PRESSED  = 2'd1,
        S_PRESSED        = 2'd2,
        S_MAYBE_RELEASED = 2'd3
    } debounce_state_t;

    localparam int unsigned BOUNCE_TICKS_DEFAULT = 4;
    localparam int unsigned REPEAT_DELAY_DEFAULT = 16;
    localparam int unsigned REPEAT_RATE_DEFAULT  = 4;

endpackage

// File: rtl/synchronizer.sv
// Two-flop level synchronizer for asynchronous inputs; both stages reset to 0.
module synchronizer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the raw level through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a clean level plus press, release and
// auto-repeat strobes, sampled on a shared slow tick.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned BOUNCE_TICKS = BOUNCE_TICKS_DEFAULT,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic debounced,
    output logic pressed,
    output logic released,
    output logic repeat_strobe
);

    localparam int unsigned REPEAT_MAX =
        (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned BCNT_W = $clog2(BOUNCE_TICKS + 1);
    localparam int unsigned RCNT_W = $clog2(REPEAT_MAX + 1);

    localparam logic [BCNT_W-1:0] BOUNCE_LAST = BCNT_W'(BOUNCE_TICKS - 1);
    localparam logic [RCNT_W-1:0] DELAY_LIM   = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RATE_LIM    = RCNT_W'(REPEAT_RATE);

    generate
        if (BOUNCE_TICKS < 1) begin : g_bad_bounce
            $error("button_debouncer: BOUNCE_TICKS must be >= 1");
        end
        if (REPEAT_RATE < 1) begin : g_bad_rate
            $error("button_debouncer: REPEAT_RATE must be >= 1");
        end
    endgenerate

    logic btn_s;

    synchronizer #(
        .WIDTH(1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (button),
        .q  (btn_s)
    );

    debounce_state_t   state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    // Set once the first (delayed) repeat has fired; selects the repeat period.
    logic              first_done_q, first_done_d;
    logic              debounced_q, debounced_d;
    logic              pressed_q, pressed_d;
    logic              released_q, released_d;
    logic              repeat_q, repeat_d;

    logic [RCNT_W-1:0] rcnt_inc;
    logic [RCNT_W-1:0] rcnt_limit;

    // Repeat counter helpers: next count and the current period limit.
    always_comb begin
        rcnt_inc   = rcnt_q + 1'b1;
        rcnt_limit = first_done_q ? RATE_LIM : DELAY_LIM;
    end

    // Debounce FSM, bounce/repeat counters and registered-output next state.
    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        rcnt_d       = rcnt_q;
        first_done_d = first_done_q;
        pressed_d    = 1'b0;
        released_d   = 1'b0;
        repeat_d     = 1'b0;

        unique case (state_q)
            S_RELEASED: begin
                if (btn_s) begin
                    state_d = S_MAYBE_PRESSED;
                    bcnt_d  = '0;
                end
            end
            S_MAYBE_PRESSED: begin
                // Disagreement wins over a coincident tick.
                if (!btn_s) begin
                    state_d = S_RELEASED;
                    bcnt_d  = '0;
                end else if (tick) begin
                    if (bcnt_q == BOUNCE_LAST) begin
                        state_d      = S_PRESSED;
                        bcnt_d       = '0;
                        rcnt_d       = '0;
                        first_done_d = 1'b0;
                        pressed_d    = 1'b1;
                        repeat_d     = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_PRESSED: begin
                if (!btn_s) begin
                    state_d = S_MAYBE_RELEASED;
                    bcnt_d  = '0;
                end else if (tick && (REPEAT_DELAY != 0)) begin
                    // Reload at the limit so the counter never wraps.
                    if (rcnt_inc >= rcnt_limit) begin
                        rcnt_d       = '0;
                        first_done_d = 1'b1;
                        repeat_d     = 1'b1;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
            end
            S_MAYBE_RELEASED: begin
                // Returning to PRESSED keeps rcnt so the cadence resumes.
                if (btn_s) begin
                    state_d = S_PRESSED;
                    bcnt_d  = '0;
                end else if (tick) begin
                    if (bcnt_q == BOUNCE_LAST) begin
                        state_d    = S_RELEASED;
                        bcnt_d     = '0;
                        released_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_RELEASED;
                bcnt_d  = '0;
            end
        endcase

        debounced_d = (state_d == S_PRESSED) || (state_d == S_MAYBE_RELEASED);
    end

    // State, counters and registered outputs with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RELEASED;
            bcnt_q       <= '0;
            rcnt_q       <= '0;
            first_done_q <= 1'b0;
            debounced_q  <= 1'b0;
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            rcnt_q       <= rcnt_d;
            first_done_q <= first_done_d;
            debounced_q  <= debounced_d;
            pressed_q    <= pressed_d;
            released_q   <= released_d;
            repeat_q     <= repeat_d;
        end
    end

    assign debounced     = debounced_q;
    assign pressed       = pressed_q;
    assign released      = released_q;
    assign repeat_strobe = repeat_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: BOUNCE_TICKS=3, REPEAT_DELAY=4,
// REPEAT_RATE=2, tick high one cycle in every four. Steps are counted in
// clock edges after an aligning tick edge P0; expected values are per step.
module tb_button_debouncer;

    logic clk;
    logic rst;
    logic tick;
    logic button;
    logic debounced;
    logic pressed;
    logic released;
    logic repeat_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;

    button_debouncer #(
        .BOUNCE_TICKS(3),
        .REPEAT_DELAY(4),
        .REPEAT_RATE (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .button       (button),
        .debounced    (debounced),
        .pressed      (pressed),
        .released     (released),
        .repeat_strobe(repeat_strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: high for one clock in every four, changed on negedge.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick  = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the sample just after a tick edge (bounded).
    task automatic align();
        int n;
        n = 0;
        step();
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        n_checks++;
        if (tick !== 1'b1) begin
            $display("FAIL align: tick=%b required 1", tick);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst    = 1'b0;
        button = 1'b0;
        #2;
        obs = {debounced, pressed, released, repeat_strobe};
        n_checks++;
        if (obs !== 4'b0000) begin
            $display("FAIL reset_initial: {deb,prs,rel,rep}=%b required 0000", obs);
            n_fail++;
        end
        for (int i = 0; i < 7; i++) begin
            if (i == 3) rst = 1'b1;
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            n_checks++;
            if (obs !== 4'b0000) begin
                $display("FAIL reset_idle i=%0d: {deb,prs,rel,rep}=%b required 0000", i, obs);
                n_fail++;
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] obs;
        for (int c = 0; c < 52; c++) begin
            if (c < 40 && c % 2 == 0) button = ~button;
            if (c >= 40) button = 1'b0;
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            n_checks++;
            if (obs !== 4'b0000) begin
                $display("FAIL bounce c=%0d: {deb,prs,rel,rep}=%b required 0000", c, obs);
                n_fail++;
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] obs, exp;
        align();
        button = 1'b1;
        for (int s = 1; s <= 13; s++) begin
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            exp = {s >= 12, s == 12, 1'b0, s == 12};
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL clean_press s=%0d: {deb,prs,rel,rep}=%b required %b", s, obs, exp);
                n_fail++;
            end
        end
    endtask

    // Continues directly from test_clean_press (steps 14..93 of that timeline).
    task automatic test_hold();
        logic [3:0] obs, exp;
        logic       rep;
        for (int s = 14; s <= 93; s++) begin
            step();
            rep = (s == 28) || (s > 28 && (s - 28) % 8 == 0);
            obs = {debounced, pressed, released, repeat_strobe};
            exp = {1'b1, 1'b0, 1'b0, rep};
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL hold s=%0d: {deb,prs,rel,rep}=%b required %b", s, obs, exp);
                n_fail++;
            end
        end
    endtask

    // Aligns to the tick after the last repeat (rcnt becomes 1), then drops
    // the button for one tick period; the frozen count resumes at the next tick.
    task automatic test_glitch();
        logic [3:0] obs, exp;
        logic       rep;
        align();
        button = 1'b0;
        for (int s = 1; s <= 25; s++) begin
            step();
            if (s == 4) button = 1'b1;
            rep = (s == 8) || (s == 16) || (s == 24);
            obs = {debounced, pressed, released, repeat_strobe};
            exp = {1'b1, 1'b0, 1'b0, rep};
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL glitch s=%0d: {deb,prs,rel,rep}=%b required %b", s, obs, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] obs, exp;
        align();
        button = 1'b0;
        for (int s = 1; s <= 14; s++) begin
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            exp = {s < 12, 1'b0, s == 12, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL release s=%0d: {deb,prs,rel,rep}=%b required %b", s, obs, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] obs, exp;
        align();
        button = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            exp = {s >= 12, s == 12, 1'b0, s == 12};
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL rst_hold_press s=%0d: {deb,prs,rel,rep}=%b required %b",
                         s, obs, exp);
                n_fail++;
            end
        end
        // Asynchronous assertion: outputs clear without a clock edge.
        #1;
        rst = 1'b0;
        #1;
        obs = {debounced, pressed, released, repeat_strobe};
        n_checks++;
        if (obs !== 4'b0000) begin
            $display("FAIL rst_async: {deb,prs,rel,rep}=%b required 0000", obs);
            n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            n_checks++;
            if (obs !== 4'b0000) begin
                $display("FAIL rst_held i=%0d: {deb,prs,rel,rep}=%b required 0000", i, obs);
                n_fail++;
            end
        end
        align();
        rst = 1'b1;
        for (int s = 1; s <= 14; s++) begin
            step();
            obs = {debounced, pressed, released, repeat_strobe};
            exp = {s >= 12, s == 12, 1'b0, s == 12};
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL rst_requalify s=%0d: {deb,prs,rel,rep}=%b required %b",
                         s, obs, exp);
                n_fail++;
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        button = 1'b0;
        test_reset();
        test_bounce();
        test_clean_press();
        test_hold();
        test_glitch();
        test_release();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
